idiv_unit: RTL

Multi-cycle signed integer divide/modulo functional unit. It serves the integer ALU in the EX stage, which issues `div` and `mod` operations to it. The unit answers with the same `stall` handshake the EX stage already consumes from its latency counters: `stall` rises in the issue cycle, stays high while the operation iterates, and drops for the one cycle in which `Z` is valid. It is a radix-2 restoring divider with one quotient bit per cycle and sign correction at completion.

---
 rtl/idiv_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/idiv_unit.sv
// Radix-2 restoring signed divide/modulo unit for the EX stage.
// Ports: clk, rst, sel/op/A/B issue, Z/done/div_by_zero result, stall hold.
module idiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Z,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             mod_q, mod_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             dbz_q, dbz_d;

  logic             is_div;
  logic             is_mod;
  logic             go;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] q_sgn;
  logic [WIDTH-1:0] r_sgn;

  assign is_div = (op == 4'b0100);
  assign is_mod = (op == 4'b0101);
  assign go     = sel & (is_div | is_mod);

  // Unsigned negate keeps |INT_MIN| = INT_MIN as a magnitude.
  assign a_neg = A[WIDTH-1];
  assign b_neg = B[WIDTH-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  // quo_q starts as |A|; its MSB feeds the remainder each step
  // while quotient bits fill in from the LSB.
  assign trial  = {rem_q, quo_q[WIDTH-1]};
  assign diff   = trial - {1'b0, dvs_q};
  assign fits   = (trial >= {1'b0, dvs_q});
  assign rem_nx = fits ? diff[WIDTH-1:0]
                       : trial[WIDTH-1:0];
  assign quo_nx = {quo_q[WIDTH-2:0], fits};

  assign q_sgn = (sa_q ^ sb_q) ? -quo_nx : quo_nx;
  assign r_sgn = sa_q ? -rem_nx : rem_nx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    mod_d   = mod_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    z_d     = z_q;
    dbz_d   = dbz_q;
    stall   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          stall = 1'b1;
          mod_d = is_mod;
          sa_d  = a_neg;
          sb_d  = b_neg;
          quo_d = a_mag;
          dvs_d = b_mag;
          rem_d = '0;
          cnt_d = CW'(WIDTH - 1);
          if (B == '0) begin
            state_d = S_DONE;
            z_d     = is_mod ? A : '1;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        stall = 1'b1;
        if (!sel) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          if (cnt_q == '0) begin
            state_d = S_DONE;
            z_d     = mod_q ? r_sgn : q_sgn;
            dbz_d   = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (rst) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      mod_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      z_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      mod_q   <= mod_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      z_q     <= z_d;
      dbz_q   <= dbz_d;
    end
  end

  assign Z           = z_q;
  assign div_by_zero = dbz_q;
  assign done        = (state_q == S_DONE);

endmodule
